// File: rtl/countdown_timer_ctrl.sv
`timescale 1ns/1ps
// countdown_timer_ctrl
// Kitchen-timer sequencer for the BCD MM:SS time-counter datapath. A preset is
// dialled in with single-cycle button pulses. The timer then counts down once
// per tick_sec. At 00:00 it raises a timed alarm and then returns to the preset.
//
// Ports
//   clk                       system clock
//   reset_n                   asynchronous active-low reset
//   tick_sec                  one-cycle pulse per second from the divider chain
//   btn_start/min/sec/clear   one-cycle debounced button pulses
//   min10,min1,sec10,sec1     BCD time digits (registered)
//   state                     0=SET 1=RUN 2=PAUSE 3=ALARM (registered)
//   alarm, running            state flags (registered)
//   blink                     display blink enable (registered)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_SET   | editing the preset; the display blinks on each tick
// S_RUN   | counting down once per tick_sec
// S_PAUSE | count frozen; the display blinks on each tick
// S_ALARM | time is 00:00; alarm held for ALARM_SEC ticks or until a button
module countdown_timer_ctrl #(
    parameter int unsigned ALARM_SEC = 10,
    parameter int unsigned MIN_MAX   = 59
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_sec,
    input  logic       btn_start,
    input  logic       btn_min,
    input  logic       btn_sec,
    input  logic       btn_clear,
    output logic [3:0] min10,
    output logic [3:0] min1,
    output logic [3:0] sec10,
    output logic [3:0] sec1,
    output logic [1:0] state,
    output logic       alarm,
    output logic       running,
    output logic       blink
);

    localparam logic [3:0] MAX10     = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX1      = 4'(MIN_MAX % 10);
    localparam logic [3:0] ALARM_END = 4'(ALARM_SEC);

    typedef enum logic [1:0] {
        S_SET   = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    state_t     st_q, st_d;
    logic [3:0] pre_m10_q, pre_m1_q, pre_s10_q, pre_s1_q;
    logic [3:0] pre_m10_d, pre_m1_d, pre_s10_d, pre_s1_d;
    logic [3:0] m10_d, m1_d, s10_d, s1_d;
    logic [3:0] acnt_q, acnt_d;
    logic       blink_d;

    logic [3:0] dm10, dm1, ds10, ds1;
    logic [3:0] im10, im1, is10, is1;
    logic       time_zero, dec_zero;
    logic       act_clear, act_start, act_min, act_sec, any_btn;

    // Only the highest-priority asserted button acts.
    assign act_clear = btn_clear;
    assign act_start = btn_start & ~btn_clear;
    assign act_min   = btn_min & ~btn_start & ~btn_clear;
    assign act_sec   = btn_sec & ~btn_min & ~btn_start & ~btn_clear;
    assign any_btn   = btn_clear | btn_start | btn_min | btn_sec;

    assign time_zero = (min10 == 4'd0) && (min1 == 4'd0) &&
                       (sec10 == 4'd0) && (sec1 == 4'd0);

    // BCD down-count by one second. The borrow ripples sec1 -> sec10 -> minutes.
    // A zero time is held, so the minutes never go below 00.
    always_comb begin
        dm10 = min10;
        dm1  = min1;
        ds10 = sec10;
        ds1  = sec1;
        if (!time_zero) begin
            if (sec1 != 4'd0) begin
                ds1 = sec1 - 4'd1;
            end else begin
                ds1 = 4'd9;
                if (sec10 != 4'd0) begin
                    ds10 = sec10 - 4'd1;
                end else begin
                    ds10 = 4'd5;
                    if (min1 != 4'd0) begin
                        dm1 = min1 - 4'd1;
                    end else begin
                        dm1  = 4'd9;
                        dm10 = min10 - 4'd1;
                    end
                end
            end
        end
    end

    assign dec_zero = (dm10 == 4'd0) && (dm1 == 4'd0) &&
                      (ds10 == 4'd0) && (ds1 == 4'd0);

    // SET-mode increments: minutes wrap at MIN_MAX, seconds wrap at 59,
    // and neither carries into the other.
    always_comb begin
        im10 = min10;
        im1  = min1 + 4'd1;
        if ((min10 == MAX10) && (min1 == MAX1)) begin
            im10 = 4'd0;
            im1  = 4'd0;
        end else if (min1 == 4'd9) begin
            im10 = min10 + 4'd1;
            im1  = 4'd0;
        end
        is10 = sec10;
        is1  = sec1 + 4'd1;
        if ((sec10 == 4'd5) && (sec1 == 4'd9)) begin
            is10 = 4'd0;
            is1  = 4'd0;
        end else if (sec1 == 4'd9) begin
            is10 = sec10 + 4'd1;
            is1  = 4'd0;
        end
    end

    always_comb begin
        st_d      = st_q;
        m10_d     = min10;
        m1_d      = min1;
        s10_d     = sec10;
        s1_d      = sec1;
        pre_m10_d = pre_m10_q;
        pre_m1_d  = pre_m1_q;
        pre_s10_d = pre_s10_q;
        pre_s1_d  = pre_s1_q;
        acnt_d    = acnt_q;

        case (st_q)
            S_SET: begin
                if (act_clear) begin
                    {m10_d, m1_d, s10_d, s1_d}                 = 16'h0000;
                    {pre_m10_d, pre_m1_d, pre_s10_d, pre_s1_d} = 16'h0000;
                end else if (act_start) begin
                    if (!time_zero) begin
                        {pre_m10_d, pre_m1_d, pre_s10_d, pre_s1_d} = {min10, min1, sec10, sec1};
                        st_d = S_RUN;
                    end
                end else if (act_min) begin
                    m10_d = im10;
                    m1_d  = im1;
                end else if (act_sec) begin
                    s10_d = is10;
                    s1_d  = is1;
                end
            end
            S_RUN: begin
                if (act_clear) begin
                    {m10_d, m1_d, s10_d, s1_d} = {pre_m10_q, pre_m1_q, pre_s10_q, pre_s1_q};
                    st_d = S_SET;
                end else begin
                    if (tick_sec) begin
                        {m10_d, m1_d, s10_d, s1_d} = {dm10, dm1, ds10, ds1};
                    end
                    // Reaching 00:00 overrides a simultaneous pause request.
                    if (tick_sec && dec_zero) begin
                        st_d   = S_ALARM;
                        acnt_d = 4'd0;
                    end else if (act_start) begin
                        st_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (act_clear) begin
                    {m10_d, m1_d, s10_d, s1_d} = {pre_m10_q, pre_m1_q, pre_s10_q, pre_s1_q};
                    st_d = S_SET;
                end else if (act_start) begin
                    st_d = S_RUN;
                end
            end
            S_ALARM: begin
                if (any_btn) begin
                    {m10_d, m1_d, s10_d, s1_d} = {pre_m10_q, pre_m1_q, pre_s10_q, pre_s1_q};
                    st_d = S_SET;
                end else if (tick_sec) begin
                    acnt_d = acnt_q + 4'd1;
                    if ((acnt_q + 4'd1) == ALARM_END) begin
                        {m10_d, m1_d, s10_d, s1_d} = {pre_m10_q, pre_m1_q, pre_s10_q, pre_s1_q};
                        st_d = S_SET;
                    end
                end
            end
            default: st_d = S_SET;
        endcase

        // Any state entry restarts blink at 1. Blink is solid in RUN and
        // ALARM. It toggles per tick only while the FSM stays in SET or PAUSE.
        if ((st_d == S_RUN) || (st_d == S_ALARM) || (st_d != st_q)) begin
            blink_d = 1'b1;
        end else if (tick_sec) begin
            blink_d = ~blink;
        end else begin
            blink_d = blink;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q      <= S_SET;
            min10     <= 4'd0;
            min1      <= 4'd0;
            sec10     <= 4'd0;
            sec1      <= 4'd0;
            pre_m10_q <= 4'd0;
            pre_m1_q  <= 4'd0;
            pre_s10_q <= 4'd0;
            pre_s1_q  <= 4'd0;
            acnt_q    <= 4'd0;
            alarm     <= 1'b0;
            running   <= 1'b0;
            blink     <= 1'b1;
        end else begin
            st_q      <= st_d;
            min10     <= m10_d;
            min1      <= m1_d;
            sec10     <= s10_d;
            sec1      <= s1_d;
            pre_m10_q <= pre_m10_d;
            pre_m1_q  <= pre_m1_d;
            pre_s10_q <= pre_s10_d;
            pre_s1_q  <= pre_s1_d;
            acnt_q    <= acnt_d;
            alarm     <= (st_d == S_ALARM);
            running   <= (st_d == S_RUN);
            blink     <= blink_d;
        end
    end

    assign state = st_q;

endmodule
